attn_spike_scheduler: RTL and testbench

ATTN_SPIKE_SCHEDULER -- requirements
Module: attn_spike_scheduler

---
 rtl/attn_spike_scheduler.sv | 148 ++++++++++++++
 tb/tb_attn_spike_scheduler.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/attn_spike_scheduler.sv
// Spike attention read scheduler: walks Q/K token blocks per head, issues paired RAM reads
// and presents aligned operand beats to the attention PE through a two-stage stallable pipeline.
module attn_spike_scheduler #(
    parameter int UNIT_NUM   = 16,
    parameter int TIME_STEPS = 4,
    parameter int HEAD_NUM   = 12,
    parameter int TOK_BLK    = 4,
    parameter int ADDR_W     = 10
) (
    input  logic                                s_clk,
    input  logic                                s_rst,
    input  logic                                i_start,
    input  logic [$clog2(HEAD_NUM+1)-1:0]       i_head_num,
    input  logic                                i_SpikesTmpRam_Ready,
    input  logic                                i_AttnRAM_Ready,
    output logic [ADDR_W-1:0]                   o_QueryRam_rdaddr,
    output logic [ADDR_W-1:0]                   o_KeyRam_rdaddr,
    output logic                                o_Ram_rden,
    input  logic [2*UNIT_NUM*TIME_STEPS-1:0]    i_QueryRam_out,
    input  logic [2*UNIT_NUM*TIME_STEPS-1:0]    i_KeyRam_out,
    output logic [2*UNIT_NUM*TIME_STEPS-1:0]    o_pe_query,
    output logic [2*UNIT_NUM*TIME_STEPS-1:0]    o_pe_key,
    output logic                                o_pe_valid,
    output logic                                o_pe_last,
    output logic [$clog2(HEAD_NUM)-1:0]         o_pe_head,
    output logic                                o_busy,
    output logic                                o_done
);
    localparam int DW  = 2*UNIT_NUM*TIME_STEPS;
    localparam int UW  = (UNIT_NUM > 1) ? $clog2(UNIT_NUM) : 1;
    localparam int BW  = (TOK_BLK > 1) ? $clog2(TOK_BLK) : 1;
    localparam int HW  = $clog2(HEAD_NUM);
    localparam int HNW = $clog2(HEAD_NUM+1);
    localparam logic [ADDR_W-1:0] A_UNIT   = ADDR_W'(UNIT_NUM);
    localparam logic [ADDR_W-1:0] A_STRIDE = ADDR_W'(HEAD_NUM*UNIT_NUM);

    typedef enum logic [2:0] {S_IDLE, S_ARM, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t            r_state, w_next;
    logic [HNW-1:0]    r_hcnt;
    logic [UW-1:0]     r_qw, r_kw;
    logic [BW-1:0]     r_qb, r_kb;
    logic [HW-1:0]     r_h;
    logic              r_drain;
    logic              r_vld_p0, r_last_p0, r_vld_p1, r_last_p1;
    logic [HW-1:0]     r_head_p0, r_head_p1;
    logic [DW-1:0]     r_query_p1, r_key_p1;
    logic              w_en, w_issue, w_last_issue;
    logic              w_qw_max, w_qb_max, w_kw_max, w_kb_max, w_h_max;
    logic [HNW-1:0]    w_hclamp;

    assign w_en         = i_AttnRAM_Ready;
    assign w_issue      = (r_state == S_RUN) && w_en;
    assign w_qw_max     = (r_qw == UW'(UNIT_NUM-1));
    assign w_qb_max     = (r_qb == BW'(TOK_BLK-1));
    assign w_kw_max     = (r_kw == UW'(UNIT_NUM-1));
    assign w_kb_max     = (r_kb == BW'(TOK_BLK-1));
    assign w_h_max      = (HNW'(r_h) == r_hcnt - HNW'(1));
    assign w_last_issue = w_issue && w_qw_max && w_qb_max && w_kw_max && w_kb_max && w_h_max;
    assign w_hclamp     = (i_head_num > HNW'(HEAD_NUM)) ? HNW'(HEAD_NUM) : i_head_num;

    // Block stride skips over the other heads interleaved in the same RAM.
    assign o_QueryRam_rdaddr = ADDR_W'(r_h)*A_UNIT + ADDR_W'(r_qb)*A_STRIDE + ADDR_W'(r_qw);
    assign o_KeyRam_rdaddr   = ADDR_W'(r_h)*A_UNIT + ADDR_W'(r_kb)*A_STRIDE + ADDR_W'(r_kw);

    always_ff @(posedge s_clk) begin
        if (s_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_next = (i_head_num == '0) ? S_DONE : S_ARM;
            S_ARM:   if (i_SpikesTmpRam_Ready) w_next = S_RUN;
            S_RUN:   if (w_last_issue) w_next = S_DRAIN;
            S_DRAIN: if (w_en && r_drain) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_Ram_rden = ((r_state == S_RUN) || (r_state == S_DRAIN)) && w_en;
        o_busy     = (r_state != S_IDLE);
        o_done     = (r_state == S_DONE);
    end

    always_ff @(posedge s_clk) begin
        if (s_rst) begin
            r_hcnt  <= '0;
            r_qw    <= '0;
            r_qb    <= '0;
            r_kw    <= '0;
            r_kb    <= '0;
            r_h     <= '0;
            r_drain <= 1'b0;
        end else begin
            if ((r_state == S_IDLE) && i_start) r_hcnt <= w_hclamp;
            if ((r_state == S_DRAIN) && w_en) r_drain <= ~r_drain;
            // Counters wrap to zero after the final issue, leaving them ready for the next pass.
            if (w_issue) begin
                r_qw <= w_qw_max ? '0 : r_qw + UW'(1);
                if (w_qw_max) begin
                    r_qb <= w_qb_max ? '0 : r_qb + BW'(1);
                    if (w_qb_max) begin
                        r_kw <= w_kw_max ? '0 : r_kw + UW'(1);
                        if (w_kw_max) begin
                            r_kb <= w_kb_max ? '0 : r_kb + BW'(1);
                            if (w_kb_max) r_h <= w_h_max ? '0 : r_h + HW'(1);
                        end
                    end
                end
            end
        end
    end

    // p0: beat tags alongside the synchronous RAM read
    // p1: RAM data and tags registered for the PE
    always_ff @(posedge s_clk) begin
        if (s_rst) begin
            r_vld_p0   <= 1'b0;
            r_last_p0  <= 1'b0;
            r_head_p0  <= '0;
            r_vld_p1   <= 1'b0;
            r_last_p1  <= 1'b0;
            r_head_p1  <= '0;
            r_query_p1 <= '0;
            r_key_p1   <= '0;
        end else if (w_en) begin
            r_vld_p0   <= w_issue;
            r_last_p0  <= w_qw_max && w_qb_max;
            r_head_p0  <= r_h;
            r_vld_p1   <= r_vld_p0;
            r_last_p1  <= r_last_p0;
            r_head_p1  <= r_head_p0;
            r_query_p1 <= i_QueryRam_out;
            r_key_p1   <= i_KeyRam_out;
        end
    end

    assign o_pe_valid = r_vld_p1 && w_en;
    assign o_pe_last  = r_last_p1 && o_pe_valid;
    assign o_pe_head  = r_head_p1;
    assign o_pe_query = r_query_p1;
    assign o_pe_key   = r_key_p1;

endmodule

// File: tb/tb_attn_spike_scheduler.sv
// Directed bench for attn_spike_scheduler with UNIT_NUM=2, TOK_BLK=2, HEAD_NUM=3, ADDR_W=10;
// the Q/K RAM models return their own read address so each beat identifies its operands.
module tb_attn_spike_scheduler;
    localparam int UNIT_NUM = 2, TIME_STEPS = 4, HEAD_NUM = 3, TOK_BLK = 2, ADDR_W = 10;
    localparam int DW = 2*UNIT_NUM*TIME_STEPS;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [1:0]        head_num = '0;
    logic              spk_rdy = 1'b1;
    logic              attn_rdy = 1'b1;
    logic [ADDR_W-1:0] q_addr, k_addr;
    logic              rden;
    logic [DW-1:0]     q_out = '0, k_out = '0;
    logic [DW-1:0]     pe_q, pe_k;
    logic              pe_valid, pe_last, busy, done;
    logic [1:0]        pe_head;

    int n_vec = 0, n_mis = 0, rden_cnt = 0, done_cnt = 0;
    logic [34:0] beats[$];
    logic [34:0] exp_q[$];

    attn_spike_scheduler #(.UNIT_NUM(UNIT_NUM), .TIME_STEPS(TIME_STEPS), .HEAD_NUM(HEAD_NUM),
                           .TOK_BLK(TOK_BLK), .ADDR_W(ADDR_W)) dut (
        .s_clk(clk), .s_rst(rst), .i_start(start), .i_head_num(head_num),
        .i_SpikesTmpRam_Ready(spk_rdy), .i_AttnRAM_Ready(attn_rdy),
        .o_QueryRam_rdaddr(q_addr), .o_KeyRam_rdaddr(k_addr), .o_Ram_rden(rden),
        .i_QueryRam_out(q_out), .i_KeyRam_out(k_out),
        .o_pe_query(pe_q), .o_pe_key(pe_k), .o_pe_valid(pe_valid), .o_pe_last(pe_last),
        .o_pe_head(pe_head), .o_busy(busy), .o_done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (rden) begin
        q_out <= {6'h2A, q_addr};
        k_out <= {6'h15, k_addr};
    end

    always @(negedge clk) begin
        if (pe_valid) beats.push_back({pe_head, pe_last, pe_q, pe_k});
        if (rden) rden_cnt++;
        if (done) done_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [1:0] n);
        start = 1'b1; head_num = n;
        tick();
        start = 1'b0;
    endtask

    // Returns the cycle (start-sampling edge = cycle 0) in which o_done is seen.
    task automatic wait_done(input int from, output int cyc);
        cyc = from;
        while (!done && cyc < 400) begin
            tick();
            cyc++;
        end
        if (!done) check("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic build_expected(input int heads);
        exp_q.delete();
        for (int h = 0; h < heads; h++)
            for (int kb = 0; kb < 2; kb++)
                for (int kw = 0; kw < 2; kw++)
                    for (int qb = 0; qb < 2; qb++)
                        for (int qw = 0; qw < 2; qw++)
                            exp_q.push_back({2'(h), (qb == 1 && qw == 1),
                                             6'h2A, 10'(h*2 + qb*6 + qw),
                                             6'h15, 10'(h*2 + kb*6 + kw)});
    endtask

    task automatic compare_beats(input string tag);
        check({tag, "_count"}, 64'(beats.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < beats.size(); i++)
            check(tag, 64'(beats[i]), 64'(exp_q[i]));
    endtask

    initial begin
        int cyc, rd0, dn0;
        int qlist[4];
        logic [ADDR_W-1:0] hold_q, hold_k;
        qlist = '{0, 1, 6, 7};

        // Reset state
        tick(); tick();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_rden", 64'(rden), 64'd0);
        check("rst_valid", 64'(pe_valid), 64'd0);
        check("rst_qaddr", 64'(q_addr), 64'd0);
        check("rst_pe_q", 64'(pe_q), 64'd0);
        rst = 1'b0;
        tick();

        // One head, no stalls
        beats.delete(); rd0 = rden_cnt;
        do_start(2'd1);
        check("a_busy", 64'(busy), 64'd1);
        wait_done(1, cyc);
        check("a_done_cycle", 64'(cyc), 64'd20);
        check("a_rden_cycles", 64'(rden_cnt - rd0), 64'd18);
        check("a_beats", 64'(beats.size()), 64'd16);
        for (int i = 0; i < 16 && i < beats.size(); i++) begin
            check("a_qaddr", 64'(beats[i][25:16]), 64'(qlist[i % 4]));
            check("a_kaddr", 64'(beats[i][9:0]), 64'(qlist[i / 4]));
            check("a_last", 64'(beats[i][32]), 64'(i % 4 == 3));
        end
        tick();
        check("a_idle_busy", 64'(busy), 64'd0);
        check("a_idle_done", 64'(done), 64'd0);

        // Three heads
        beats.delete();
        do_start(2'd3);
        wait_done(1, cyc);
        check("b_done_cycle", 64'(cyc), 64'd52);
        build_expected(3);
        compare_beats("b_beat");
        for (int i = 0; i < 4 && 32 + i < beats.size(); i++)
            check("b_head2_qaddr", 64'(beats[32+i][25:16]), 64'(4 + (i % 2) + (i / 2) * 6));
        if (beats.size() == 48) begin
            check("b_head0", 64'(beats[0][34:33]), 64'd0);
            check("b_head1", 64'(beats[16][34:33]), 64'd1);
            check("b_head2", 64'(beats[32][34:33]), 64'd2);
        end
        tick();

        // Three-cycle downstream stall mid-run
        beats.delete();
        do_start(2'd1);
        for (int i = 1; i < 8; i++) tick();
        attn_rdy = 1'b0;
        hold_q = q_addr; hold_k = k_addr;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("c_stall_valid", 64'(pe_valid), 64'd0);
            check("c_stall_rden", 64'(rden), 64'd0);
            check("c_stall_qaddr", 64'(q_addr), 64'(hold_q));
            check("c_stall_kaddr", 64'(k_addr), 64'(hold_k));
            tick();
        end
        attn_rdy = 1'b1;
        wait_done(11, cyc);
        check("c_done_cycle", 64'(cyc), 64'd23);
        build_expected(1);
        compare_beats("c_beat");
        tick();

        // Zero heads, then a start while busy is ignored
        rd0 = rden_cnt; dn0 = done_cnt;
        do_start(2'd0);
        check("d_done", 64'(done), 64'd1);
        start = 1'b1; head_num = 2'd1;
        tick();
        start = 1'b0;
        check("d_done_gone", 64'(done), 64'd0);
        check("d_busy", 64'(busy), 64'd0);
        for (int i = 0; i < 4; i++) tick();
        check("d_busy_later", 64'(busy), 64'd0);
        check("d_no_reads", 64'(rden_cnt - rd0), 64'd0);
        check("d_done_pulses", 64'(done_cnt - dn0), 64'd1);

        // Spikes not ready: hold in ARM, then reset on the seventh beat
        spk_rdy = 1'b0; beats.delete(); rd0 = rden_cnt;
        do_start(2'd1);
        for (int i = 0; i < 5; i++) begin
            check("e_arm_busy", 64'(busy), 64'd1);
            if (i < 4) tick();
        end
        check("e_arm_reads", 64'(rden_cnt - rd0), 64'd0);
        spk_rdy = 1'b1;
        cyc = 0;
        while (beats.size() < 7 && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        check("e_beat7_reached", 64'(beats.size()), 64'd7);
        rst = 1'b1; dn0 = done_cnt;
        tick();
        check("e_rst_valid", 64'(pe_valid), 64'd0);
        check("e_rst_last", 64'(pe_last), 64'd0);
        check("e_rst_head", 64'(pe_head), 64'd0);
        check("e_rst_pe_q", 64'(pe_q), 64'd0);
        check("e_rst_pe_k", 64'(pe_k), 64'd0);
        check("e_rst_qaddr", 64'(q_addr), 64'd0);
        check("e_rst_kaddr", 64'(k_addr), 64'd0);
        check("e_rst_rden", 64'(rden), 64'd0);
        check("e_rst_busy", 64'(busy), 64'd0);
        check("e_rst_done", 64'(done), 64'd0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("e_no_done", 64'(done_cnt - dn0), 64'd0);
        check("e_idle", 64'(busy), 64'd0);

        // Fresh pass after the abort starts from head 0
        beats.delete();
        do_start(2'd1);
        wait_done(1, cyc);
        check("f_done_cycle", 64'(cyc), 64'd20);
        build_expected(1);
        compare_beats("f_beat");
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
